// File: rtl/data_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared definitions for the data-memory arbiter: the arbiter state enum,
// the default word/address widths and the modulo increment used by the
// round-robin pointer.
// ---------------------------------------------------------------------------
package data_mem_arb_pkg;

  // LOCKED is only reachable when DATA_MEM_ARB_LOCK_EN is defined
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arbState_t;

  localparam int DEFAULT_REG_WIDTH           = 12;
  localparam int DEFAULT_DATA_MEM_ADDR_WIDTH = 12;

  // Increment an index modulo n, so the pointer works for any core count
  function automatic int next_index(input int idx, input int n);
    if (idx + 1 >= n) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational first-set search over a request vector, starting at a
// rotating pointer and wrapping modulo N.
// Ports:
//   req   - request vector
//   ptr   - index that has highest priority this cycle (0..N-1)
//   grant - one-hot winner (all zero when no request)
//   idx   - binary index of the winner
//   valid - at least one request was found
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan ptr, ptr+1, ... with explicit wrap; the first hit wins
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port data RAM (registered read) among NUM_CORES cores.
// One access is granted per cycle in round-robin order; read data returns
// one cycle after the grant with a one-hot valid strobe.
// Optional feature: define DATA_MEM_ARB_LOCK_EN to add coreLock, which lets
// a core hold exclusive ownership for atomic read-modify-write sequences.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   coreReq/coreWrEn      - per-core request and write qualifier
//   coreAddr/coreDataOut  - packed per-core address and write data
//   coreLock              - per-core lock request (lock build only)
//   coreGrant             - combinational one-hot grant
//   coreRdValid/coreRdData- read response, one cycle after a read grant
//   memAddr/memDataIn/memWrEn/memDataOut - shared RAM interface
//   busy                  - a request or an in-flight read exists
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int NUM_CORES           = 4,
  parameter int REG_WIDTH           = DEFAULT_REG_WIDTH,
  parameter int DATA_MEM_ADDR_WIDTH = DEFAULT_DATA_MEM_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CORES-1:0]                coreReq,
  input  logic [NUM_CORES-1:0]                coreWrEn,
  input  logic [NUM_CORES*DATA_MEM_ADDR_WIDTH-1:0] coreAddr,
  input  logic [NUM_CORES*REG_WIDTH-1:0]      coreDataOut,
`ifdef DATA_MEM_ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]                coreLock,
`endif
  output logic [NUM_CORES-1:0]                coreGrant,
  output logic [NUM_CORES-1:0]                coreRdValid,
  output logic [REG_WIDTH-1:0]                coreRdData,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]      memAddr,
  output logic [REG_WIDTH-1:0]                memDataIn,
  output logic                                memWrEn,
  input  logic [REG_WIDTH-1:0]                memDataOut,
  output logic                                busy
);

  localparam int IDX_W = $clog2(NUM_CORES);

  arbState_t                    state;
  logic [IDX_W-1:0]             rrPtr;
  logic                         rdPending;
  logic [IDX_W-1:0]             rdIdx;
  logic [DATA_MEM_ADDR_WIDTH-1:0] lastAddr;

  logic [NUM_CORES-1:0] pickGrant;
  logic [IDX_W-1:0]     pickIdx;
  logic                 pickValid;

  logic                 lockedReq;
  logic [IDX_W-1:0]     lockedIdx;
  logic                 winValid;
  logic [IDX_W-1:0]     winIdx;
  logic                 grantValid;
  logic                 winWrEn;
  logic                 anyReq;

  rr_priority_picker #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) picker (
    .req   (coreReq),
    .ptr   (rrPtr),
    .grant (pickGrant),
    .idx   (pickIdx),
    .valid (pickValid)
  );

`ifdef DATA_MEM_ARB_LOCK_EN
  logic [IDX_W-1:0] owner;
  assign lockedReq = coreReq[owner];
  assign lockedIdx = owner;
`else
  assign lockedReq = 1'b0;
  assign lockedIdx = '0;
`endif

  // While locked only the owner may win; otherwise the round-robin pick wins
  assign winValid   = (state == LOCKED) ? lockedReq : pickValid;
  assign winIdx     = (state == LOCKED) ? lockedIdx : pickIdx;
  assign grantValid = winValid && !rst;
  assign winWrEn    = coreWrEn[winIdx];
  assign anyReq     = |coreReq;

  // Route the winner onto the shared RAM; the address holds when idle
  always_comb begin
    coreGrant = '0;
    memWrEn   = 1'b0;
    memDataIn = '0;
    memAddr   = rst ? '0 : lastAddr;
    if (grantValid) begin
      if (state == LOCKED) coreGrant[winIdx] = 1'b1;
      else                 coreGrant = pickGrant;
      memWrEn   = winWrEn;
      memAddr   = coreAddr[int'(winIdx)*DATA_MEM_ADDR_WIDTH +: DATA_MEM_ADDR_WIDTH];
      memDataIn = coreDataOut[int'(winIdx)*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Read response lines up with the RAM's registered output; a reset in the
  // response cycle suppresses it so the dropped read never reports valid
  always_comb begin
    coreRdValid = '0;
    coreRdData  = '0;
    if (rdPending && !rst) begin
      coreRdValid[rdIdx] = 1'b1;
      coreRdData         = memDataOut;
    end
  end

  assign busy = !rst && (anyReq || rdPending);

  // Arbiter state, round-robin pointer and in-flight read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rrPtr     <= '0;
      rdPending <= 1'b0;
      rdIdx     <= '0;
      lastAddr  <= '0;
`ifdef DATA_MEM_ARB_LOCK_EN
      owner     <= '0;
`endif
    end else begin
      rdPending <= grantValid && !winWrEn;
      rdIdx     <= winIdx;
      lastAddr  <= memAddr;
`ifdef DATA_MEM_ARB_LOCK_EN
      if (state == LOCKED) begin
        if (!coreReq[owner] || !coreLock[owner]) begin
          rrPtr <= IDX_W'(next_index(int'(owner), NUM_CORES));
          state <= anyReq ? GRANT : IDLE;
        end
      end else if (grantValid && coreLock[winIdx]) begin
        state <= LOCKED;
        owner <= winIdx;
      end else begin
        if (grantValid) rrPtr <= IDX_W'(next_index(int'(winIdx), NUM_CORES));
        state <= anyReq ? GRANT : IDLE;
      end
`else
      if (grantValid) rrPtr <= IDX_W'(next_index(int'(winIdx), NUM_CORES));
      state <= anyReq ? GRANT : IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Self-checking bench for data_mem_arbiter with a registered-read RAM model,
// directed scenarios and a randomized run against a round-robin reference.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;

  logic              clk;
  logic              rst;
  logic [N-1:0]      coreReq;
  logic [N-1:0]      coreWrEn;
  logic [N*AW-1:0]   coreAddr;
  logic [N*DW-1:0]   coreDataOut;
`ifdef DATA_MEM_ARB_LOCK_EN
  logic [N-1:0]      coreLock;
`endif
  logic [N-1:0]      coreGrant;
  logic [N-1:0]      coreRdValid;
  logic [DW-1:0]     coreRdData;
  logic [AW-1:0]     memAddr;
  logic [DW-1:0]     memDataIn;
  logic              memWrEn;
  logic [DW-1:0]     memDataOut;
  logic              busy;

  int checkCount = 0;
  int passCount  = 0;

  logic [DW-1:0] ram    [0:4095];
  logic [DW-1:0] shadow [0:4095];

  data_mem_arbiter #(
    .NUM_CORES           (N),
    .REG_WIDTH           (DW),
    .DATA_MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coreReq     (coreReq),
    .coreWrEn    (coreWrEn),
    .coreAddr    (coreAddr),
    .coreDataOut (coreDataOut),
`ifdef DATA_MEM_ARB_LOCK_EN
    .coreLock    (coreLock),
`endif
    .coreGrant   (coreGrant),
    .coreRdValid (coreRdValid),
    .coreRdData  (coreRdData),
    .memAddr     (memAddr),
    .memDataIn   (memDataIn),
    .memWrEn     (memWrEn),
    .memDataOut  (memDataOut),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] initVal(input int a);
    if (a == 16) return 12'hABC;
    return DW'((a * 37 + 5) ^ 'h2C3);
  endfunction

  // Registered-read RAM; contents reload whenever reset is applied
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= initVal(i);
    end else if (memWrEn) begin
      ram[memAddr] <= memDataIn;
    end
    memDataOut <= ram[memAddr];
  end

  task automatic clearInputs();
    coreReq     = '0;
    coreWrEn    = '0;
    coreAddr    = '0;
    coreDataOut = '0;
`ifdef DATA_MEM_ARB_LOCK_EN
    coreLock    = '0;
`endif
  endtask

  task automatic applyStimulus(input int core, input bit req, input bit wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    coreReq[core]                = req;
    coreWrEn[core]               = wr;
    coreAddr[core*AW +: AW]      = addr;
    coreDataOut[core*DW +: DW]   = data;
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b1;
    clearInputs();
    for (int i = 0; i < 4096; i++) shadow[i] = initVal(i);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 12'h123, 12'h456);
    applyStimulus(2, 1'b1, 1'b0, 12'h321, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0000) $display("[TB] FAIL reset_grant got=%b exp=%b", coreGrant, 4'b0000); else passCount++;
    checkCount++; if (memWrEn !== 1'b0) $display("[TB] FAIL reset_memWrEn got=%b exp=0", memWrEn); else passCount++;
    checkCount++; if (memAddr !== 12'h000) $display("[TB] FAIL reset_memAddr got=%h exp=000", memAddr); else passCount++;
    checkCount++; if (memDataIn !== 12'h000) $display("[TB] FAIL reset_memDataIn got=%h exp=000", memDataIn); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else passCount++;
    checkCount++; if (coreRdValid !== 4'b0000) $display("[TB] FAIL reset_rdValid got=%b exp=%b", coreRdValid, 4'b0000); else passCount++;
    checkCount++; if (coreRdData !== 12'h000) $display("[TB] FAIL reset_rdData got=%h exp=000", coreRdData); else passCount++;
    @(posedge clk); #1;
    clearInputs();
    for (int i = 0; i < 4096; i++) shadow[i] = initVal(i);
    rst = 1'b0;
    @(negedge clk);
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy got=%b exp=0", busy); else passCount++;
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    applyStimulus(2, 1'b1, 1'b0, 12'h010, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0100) $display("[TB] FAIL single_grant got=%b exp=%b", coreGrant, 4'b0100); else passCount++;
    checkCount++; if (memAddr !== 12'h010) $display("[TB] FAIL single_memAddr got=%h exp=010", memAddr); else passCount++;
    checkCount++; if (memWrEn !== 1'b0) $display("[TB] FAIL single_memWrEn got=%b exp=0", memWrEn); else passCount++;
    @(posedge clk); #1;
    applyStimulus(2, 1'b0, 1'b0, 12'h000, 12'h000);
    @(negedge clk);
    checkCount++; if (coreRdValid !== 4'b0100) $display("[TB] FAIL single_rdValid got=%b exp=%b", coreRdValid, 4'b0100); else passCount++;
    checkCount++; if (coreRdData !== 12'hABC) $display("[TB] FAIL single_rdData got=%h exp=abc", coreRdData); else passCount++;
    checkCount++; if (coreGrant !== 4'b0000) $display("[TB] FAIL single_nogrant got=%b exp=%b", coreGrant, 4'b0000); else passCount++;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL single_busy got=%b exp=1", busy); else passCount++;
  endtask

  // Relies on the pointer sitting at 3 after the single read by core 2
  task automatic test_pointer_wrap();
    @(posedge clk); #1;
    applyStimulus(3, 1'b1, 1'b0, 12'h003, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b1000) $display("[TB] FAIL wrap_grant3 got=%b exp=%b", coreGrant, 4'b1000); else passCount++;
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 12'h004, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0001) $display("[TB] FAIL wrap_grant0 got=%b exp=%b", coreGrant, 4'b0001); else passCount++;
    @(posedge clk); #1;
    clearInputs();
  endtask

  task automatic test_contention();
    logic [N-1:0] expG;
    applyReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 1'b0, AW'(12'h100 + i), 12'h000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expG = N'(1) << (c % N);
      checkCount++; if (coreGrant !== expG) $display("[TB] FAIL contention_grant cycle=%0d got=%b exp=%b", c, coreGrant, expG); else passCount++;
      if (c > 0) begin
        expG = N'(1) << ((c - 1) % N);
        checkCount++; if (coreRdValid !== expG) $display("[TB] FAIL contention_rdValid cycle=%0d got=%b exp=%b", c, coreRdValid, expG); else passCount++;
        checkCount++; if (coreRdData !== shadow[12'h100 + (c - 1) % N]) $display("[TB] FAIL contention_rdData cycle=%0d got=%h exp=%h", c, coreRdData, shadow[12'h100 + (c - 1) % N]); else passCount++;
      end
      @(posedge clk); #1;
    end
    clearInputs();
    @(negedge clk);
    checkCount++; if (coreRdValid !== 4'b0001) $display("[TB] FAIL contention_lastValid got=%b exp=%b", coreRdValid, 4'b0001); else passCount++;
  endtask

  task automatic test_mixed();
    applyReset();
    applyStimulus(1, 1'b1, 1'b1, 12'h020, 12'h5A5);
    applyStimulus(3, 1'b1, 1'b0, 12'h020, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0010) $display("[TB] FAIL mixed_grant1 got=%b exp=%b", coreGrant, 4'b0010); else passCount++;
    checkCount++; if (memWrEn !== 1'b1) $display("[TB] FAIL mixed_memWrEn1 got=%b exp=1", memWrEn); else passCount++;
    checkCount++; if (memAddr !== 12'h020) $display("[TB] FAIL mixed_memAddr1 got=%h exp=020", memAddr); else passCount++;
    checkCount++; if (memDataIn !== 12'h5A5) $display("[TB] FAIL mixed_memDataIn got=%h exp=5a5", memDataIn); else passCount++;
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b0, 12'h000, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b1000) $display("[TB] FAIL mixed_grant3 got=%b exp=%b", coreGrant, 4'b1000); else passCount++;
    checkCount++; if (memWrEn !== 1'b0) $display("[TB] FAIL mixed_memWrEn3 got=%b exp=0", memWrEn); else passCount++;
    @(posedge clk); #1;
    clearInputs();
    @(negedge clk);
    checkCount++; if (coreRdValid !== 4'b1000) $display("[TB] FAIL mixed_rdValid got=%b exp=%b", coreRdValid, 4'b1000); else passCount++;
    checkCount++; if (coreRdData !== 12'h5A5) $display("[TB] FAIL mixed_rdData got=%h exp=5a5", coreRdData); else passCount++;
  endtask

  task automatic test_reset_mid_read();
    applyReset();
    applyStimulus(2, 1'b1, 1'b0, 12'h010, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0100) $display("[TB] FAIL midrst_grant2 got=%b exp=%b", coreGrant, 4'b0100); else passCount++;
    @(posedge clk); #1;
    rst = 1'b1;
    clearInputs();
    applyStimulus(0, 1'b1, 1'b0, 12'h001, 12'h000);
    applyStimulus(3, 1'b1, 1'b0, 12'h002, 12'h000);
    @(negedge clk);
    checkCount++; if (coreRdValid !== 4'b0000) $display("[TB] FAIL midrst_rdValid got=%b exp=%b", coreRdValid, 4'b0000); else passCount++;
    checkCount++; if (coreGrant !== 4'b0000) $display("[TB] FAIL midrst_grant got=%b exp=%b", coreGrant, 4'b0000); else passCount++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) shadow[i] = initVal(i);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0001) $display("[TB] FAIL midrst_grant0 got=%b exp=%b", coreGrant, 4'b0001); else passCount++;
    checkCount++; if (coreRdValid !== 4'b0000) $display("[TB] FAIL midrst_noValid got=%b exp=%b", coreRdValid, 4'b0000); else passCount++;
    @(posedge clk); #1;
    clearInputs();
  endtask

  // Reference: pending requests per core, round-robin pointer as an integer,
  // a shadow memory and at most one outstanding read response
  task automatic test_random();
    bit            reqS  [N];
    bit            wrS   [N];
    logic [AW-1:0] addrS [N];
    logic [DW-1:0] dataS [N];
    int            ptr;
    int            w;
    int            c;
    bit            pend;
    int            pendCore;
    logic [DW-1:0] pendData;
    logic [AW-1:0] lastA;
    logic [N-1:0]  expG;
    logic [N-1:0]  expV;
    bit            expBusy;
    applyReset();
    ptr = 0; pend = 0; pendCore = 0; pendData = '0; lastA = '0;
    for (int i = 0; i < N; i++) begin
      reqS[i]  = ($urandom_range(0, 99) < 60);
      wrS[i]   = 1'($urandom_range(0, 1));
      addrS[i] = AW'($urandom_range(0, 15));
      dataS[i] = DW'($urandom);
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++) applyStimulus(i, reqS[i], wrS[i], addrS[i], dataS[i]);
      @(negedge clk);
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (ptr + k) % N;
        if (w < 0 && reqS[c]) w = c;
      end
      expG = (w >= 0) ? (N'(1) << w) : '0;
      expV = pend ? (N'(1) << pendCore) : '0;
      expBusy = pend;
      for (int i = 0; i < N; i++) if (reqS[i]) expBusy = 1'b1;
      checkCount++; if (coreGrant !== expG) $display("[TB] FAIL rand_grant cycle=%0d got=%b exp=%b", cyc, coreGrant, expG); else passCount++;
      checkCount++; if (memWrEn !== (w >= 0 && wrS[w])) $display("[TB] FAIL rand_memWrEn cycle=%0d got=%b exp=%b", cyc, memWrEn, (w >= 0 && wrS[w])); else passCount++;
      checkCount++; if (memAddr !== ((w >= 0) ? addrS[w] : lastA)) $display("[TB] FAIL rand_memAddr cycle=%0d got=%h exp=%h", cyc, memAddr, ((w >= 0) ? addrS[w] : lastA)); else passCount++;
      if (w >= 0 && wrS[w]) begin
        checkCount++; if (memDataIn !== dataS[w]) $display("[TB] FAIL rand_memDataIn cycle=%0d got=%h exp=%h", cyc, memDataIn, dataS[w]); else passCount++;
      end
      checkCount++; if (coreRdValid !== expV) $display("[TB] FAIL rand_rdValid cycle=%0d got=%b exp=%b", cyc, coreRdValid, expV); else passCount++;
      if (pend) begin
        checkCount++; if (coreRdData !== pendData) $display("[TB] FAIL rand_rdData cycle=%0d got=%h exp=%h", cyc, coreRdData, pendData); else passCount++;
      end
      checkCount++; if (busy !== expBusy) $display("[TB] FAIL rand_busy cycle=%0d got=%b exp=%b", cyc, busy, expBusy); else passCount++;
      pend = (w >= 0) && !wrS[w];
      if (w >= 0) begin
        if (pend) begin
          pendCore = w;
          pendData = shadow[addrS[w]];
        end else begin
          shadow[addrS[w]] = dataS[w];
        end
        lastA = addrS[w];
        ptr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (i == w || !reqS[i]) begin
          reqS[i]  = ($urandom_range(0, 99) < 60);
          wrS[i]   = 1'($urandom_range(0, 1));
          addrS[i] = AW'($urandom_range(0, 15));
          dataS[i] = DW'($urandom);
        end
      end
      @(posedge clk); #1;
    end
    clearInputs();
  endtask

`ifdef DATA_MEM_ARB_LOCK_EN
  task automatic test_lock();
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 12'h000, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0001) $display("[TB] FAIL lock_pre_grant got=%b exp=%b", coreGrant, 4'b0001); else passCount++;
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 12'h040, 12'h000);
    applyStimulus(1, 1'b1, 1'b0, 12'h030, 12'h000);
    applyStimulus(2, 1'b1, 1'b0, 12'h041, 12'h000);
    coreLock[1] = 1'b1;
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0010) $display("[TB] FAIL lock_rd_grant got=%b exp=%b", coreGrant, 4'b0010); else passCount++;
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b1, 12'h030, 12'h123);
    coreLock[1] = 1'b0;
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0010) $display("[TB] FAIL lock_wr_grant got=%b exp=%b", coreGrant, 4'b0010); else passCount++;
    checkCount++; if (memWrEn !== 1'b1) $display("[TB] FAIL lock_wr_en got=%b exp=1", memWrEn); else passCount++;
    checkCount++; if (coreRdData !== shadow[12'h030]) $display("[TB] FAIL lock_rd_data got=%h exp=%h", coreRdData, shadow[12'h030]); else passCount++;
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b0, 12'h000, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0100) $display("[TB] FAIL lock_after2 got=%b exp=%b", coreGrant, 4'b0100); else passCount++;
    @(posedge clk); #1;
    applyStimulus(2, 1'b0, 1'b0, 12'h000, 12'h000);
    @(negedge clk);
    checkCount++; if (coreGrant !== 4'b0001) $display("[TB] FAIL lock_after0 got=%b exp=%b", coreGrant, 4'b0001); else passCount++;
    @(posedge clk); #1;
    clearInputs();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clearInputs();
    test_reset();
    test_single_read();
    test_pointer_wrap();
    test_contention();
    test_mixed();
    test_reset_mid_read();
    test_random();
`ifdef DATA_MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares one single-port data memory among NUM_CORES processor cores in the multicore matrix-multiply design.
- Sits between the per-core data-memory buses and the shared data RAM.
- The shared RAM has a registered read: data appears one cycle after the address.
- Grants one access per cycle, using round-robin priority, and routes read data back to the requesting core with a valid strobe.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- REG_WIDTH, 12, data word width.
- DATA_MEM_ADDR_WIDTH, 12, data memory address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- coreReq  in  NUM_CORES  per-core access request, held until granted.
- coreWrEn  in  NUM_CORES  per-core write (1) / read (0) qualifier.
- coreAddr  in  NUM_CORES*DATA_MEM_ADDR_WIDTH  packed per-core addresses; core i occupies slice i.
- coreDataOut  in  NUM_CORES*REG_WIDTH  packed per-core write data.
- coreGrant  out  NUM_CORES  one-hot, combinational; the access is accepted this cycle.
- coreRdValid  out  NUM_CORES  one-hot; coreRdData is valid for that core this cycle.
- coreRdData  out  REG_WIDTH  read data, broadcast to all cores.
- memAddr  out  DATA_MEM_ADDR_WIDTH  shared memory address.
- memDataIn  out  REG_WIDTH  shared memory write data.
- memWrEn  out  1  shared memory write enable.
- memDataOut  in  REG_WIDTH  shared memory registered read data.
- busy  out  1  a grant or an in-flight read exists.

Behaviour:
- Reset: rrPtr=0, state=IDLE, rdPending=0, coreRdValid=0, coreRdData=0. Outputs are driven to 0 in reset cycles: coreGrant, memWrEn, memAddr, memDataIn, busy.
- Arbitration: each cycle, the winner is the first requesting index scanning rrPtr, rrPtr+1, ..., modulo NUM_CORES.
  - coreGrant[winner]=1 in the same cycle.
  - memAddr, memDataIn and memWrEn mux from the winner.
  - With no request: memWrEn=0, memAddr holds its last value, coreGrant=0.
- Pointer: after a grant, rrPtr <= winner+1, wrapping NUM_CORES-1 -> 0.
- Read latency: a read granted in cycle t gives coreRdValid[winner]=1 and coreRdData=memDataOut in cycle t+1.
  - A registered rdPending flag and rdIdx carry the granted read into cycle t+1.
- Write: completes in the grant cycle. No response strobe.
- Throughput: one access per cycle. Back-to-back reads from different cores overlap; cycle t+1 may carry both a new grant and the previous read's valid.
- A core whose req stays high after its grant is a new request. It competes normally and gets no favour.
- States:
  - IDLE: no req. Any req -> GRANT.
  - GRANT: grant issued. Stays in GRANT while any req is present, else -> IDLE.
  - LOCKED: only with the optional feature.
- busy = |coreReq | rdPending.
- Reset mid-operation: the in-flight read is dropped, so no coreRdValid is issued; rrPtr returns to 0.
- Widths: coreAddr and coreDataOut are sliced with indexed part-select. Any NUM_CORES up to 16 is legal; there is no power-of-two requirement.

Optional Feature:
- Macro: DATA_MEM_ARB_LOCK_EN.
- With the macro:
  - Adds input coreLock[NUM_CORES].
  - A grant to core i with coreLock[i]=1 moves state to LOCKED with owner=i; rrPtr is not advanced.
  - In LOCKED, only the owner can be granted; other requests stall.
  - The owner deasserting coreLock, or deasserting coreReq for one cycle, -> GRANT/IDLE with rrPtr=owner+1.
  - This supports atomic read-modify-write on shared counters.
- Without the macro: there is no coreLock port and no LOCKED state.

Decomposition:
- Shared package data_mem_arb_pkg holds:
  - the state enum IDLE/GRANT/LOCKED;
  - the default widths REG_WIDTH=12 and DATA_MEM_ADDR_WIDTH=12;
  - a function next_index(idx, n) for the modulo increment.
- One natural sub-module: rr_priority_picker.
  - Combinational first-set search from a rotating pointer.
  - Returns a one-hot grant and a binary index.

Test Plan:
- Single read: core 2 reads addr 0x010 (mem holds 0xABC) -> coreGrant=0100 at t; coreRdValid=0100 and coreRdData=0xABC at t+1.
- Full contention: all 4 cores read, req held, rrPtr=0 -> grants in order 0,1,2,3,0 on consecutive cycles; each rdValid arrives one cycle after its grant.
- Mixed traffic: core 1 writes 0x5A5 to 0x020 while core 3 reads 0x020 -> core 1 granted first, memWrEn=1; core 3 is granted the next cycle and reads 0x5A5.
- Reset mid-read: rst asserted in the cycle after a read grant -> no coreRdValid; the next grant after reset goes to core 0 when cores 0 and 3 both request.
- Pointer wrap: rrPtr=3 with only core 3 requesting -> grant 1000, rrPtr=0; next cycle cores 0 and 3 request -> core 0 granted.
- Lock (DATA_MEM_ARB_LOCK_EN): core 1 asserts lock and does read-then-write of 0x030 while cores 0 and 2 request -> both core-1 accesses are granted consecutively; after unlock, core 2 is granted, then core 0.
